// File: rtl/async_mem_pkg.sv
// rtl/async_mem_pkg.sv - shared state encoding and defaults for the async SRAM-bus Wishbone master
// Purpose: state enum and parameter defaults shared by async_mem_wb_master and wb_cycle_timer.
// Ports: none (package).
package async_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_HOLD = 3'd4,
        ST_WR_REQ  = 3'd5
    } state_t;

    localparam int          TO_CYC_DEF   = 255;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/async_mem_wb_master_timer.sv
// rtl/async_mem_wb_master_timer.sv - Wishbone cycle watchdog counter
// Purpose: counts cycles while wb_cyc is high and flags expiry at TO_CYC.
// Ports: clk, rst (async, active-high); i_run = current wb_cyc level;
//        o_expired = high during the cycle where the count reaches TO_CYC.
module wb_cycle_timer #(
    parameter int TO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expired
);
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Held at zero whenever cyc is low, so every cycle starts counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Count values 0..TO_CYC give at most TO_CYC+1 cycles of cyc high.
    assign o_expired = i_run && (r_cnt == CW'(TO_CYC));

endmodule

// File: rtl/async_mem_wb_master.sv
// rtl/async_mem_wb_master.sv - async SRAM-style host access to Wishbone classic master
// Purpose: turns each synchronised host access into one Wishbone classic cycle,
//          returns read data and wait to the host pads, posts writes with one
//          queued follow-on access.
// Ports: clk/rst; host edge pulses ce_fall/ce_rise/we_rise and levels we_n_s/oe_n_s;
//        host address/data/byte-enables in; mem_data_o/mem_data_oe/mem_wait out;
//        Wishbone master wb_*; err_o pulse on bus error or timeout.
module async_mem_wb_master
    import async_mem_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int          TO_CYC   = TO_CYC_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce_fall,
    input  logic            ce_rise,
    input  logic            we_rise,
    input  logic            we_n_s,
    input  logic            oe_n_s,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [DW-1:0]   mem_data_i,
    input  logic [DW/8-1:0] mem_be_n_i,
    output logic [DW-1:0]   mem_data_o,
    output logic            mem_data_oe,
    output logic            mem_wait,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            err_o
);
    localparam logic [DW-1:0] L_ERR_DATA = DW'(ERR_DATA);

    state_t            r_state, w_state;
    logic [AW-1:0]     r_wb_adr, w_wb_adr, r_shadow, w_shadow;
    logic [DW-1:0]     r_wb_dat, w_wb_dat, r_mem_data, w_mem_data;
    logic [DW/8-1:0]   r_wb_sel, w_wb_sel;
    logic              r_wb_we, w_wb_we, r_wb_cyc, w_wb_cyc;
    logic              r_oe, w_oe, r_wait, w_wait, r_err, w_err;
    logic              r_pend, w_pend, r_abort, w_abort;
    logic              w_expired, w_bad, w_term;

    wb_cycle_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (r_wb_cyc),
        .o_expired (w_expired)
    );

    // err wins over a simultaneous ack.
    assign w_bad  = wb_err_i || w_expired;
    assign w_term = wb_ack_i || w_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wb_adr   <= '0;
            r_shadow   <= '0;
            r_wb_dat   <= '0;
            r_mem_data <= '0;
            r_wb_sel   <= '0;
            r_wb_we    <= 1'b0;
            r_wb_cyc   <= 1'b0;
            r_oe       <= 1'b0;
            r_wait     <= 1'b0;
            r_err      <= 1'b0;
            r_pend     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_wb_adr   <= w_wb_adr;
            r_shadow   <= w_shadow;
            r_wb_dat   <= w_wb_dat;
            r_mem_data <= w_mem_data;
            r_wb_sel   <= w_wb_sel;
            r_wb_we    <= w_wb_we;
            r_wb_cyc   <= w_wb_cyc;
            r_oe       <= w_oe;
            r_wait     <= w_wait;
            r_err      <= w_err;
            r_pend     <= w_pend;
            r_abort    <= w_abort;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_wb_adr   = r_wb_adr;
        w_shadow   = r_shadow;
        w_wb_dat   = r_wb_dat;
        w_mem_data = r_mem_data;
        w_wb_sel   = r_wb_sel;
        w_wb_we    = r_wb_we;
        w_wb_cyc   = r_wb_cyc;
        w_oe       = 1'b0;
        w_err      = 1'b0;
        w_pend     = r_pend;
        w_abort    = r_abort;

        case (r_state)
            ST_IDLE: begin
                if (ce_fall) begin
                    w_wb_adr = mem_addr_i;
                    w_state  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (ce_rise) begin
                    w_state = ST_IDLE;
                end else if (!we_n_s) begin
                    w_state = ST_WR_WAIT;
                end else if (!oe_n_s) begin
                    w_wb_cyc = 1'b1;
                    w_wb_we  = 1'b0;
                    w_wb_sel = ~mem_be_n_i;
                    w_abort  = 1'b0;
                    w_state  = ST_RD_REQ;
                end
            end
            ST_WR_WAIT: begin
                if (we_rise || ce_rise) begin
                    w_wb_dat = mem_data_i;
                    w_wb_sel = ~mem_be_n_i;
                    w_wb_cyc = 1'b1;
                    w_wb_we  = 1'b1;
                    w_pend   = 1'b0;
                    w_state  = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (ce_rise) begin
                    w_abort = 1'b1;
                end
                if (w_term) begin
                    w_wb_cyc = 1'b0;
                    w_err    = w_bad;
                    w_abort  = 1'b0;
                    // A host that already let go gets nothing; keep the old pad data.
                    if (r_abort || ce_rise) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_mem_data = w_bad ? L_ERR_DATA : wb_dat_i;
                        w_state    = ST_RD_HOLD;
                    end
                end
            end
            ST_RD_HOLD: begin
                if (ce_rise) begin
                    w_state = ST_IDLE;
                end else begin
                    w_oe = ~oe_n_s;
                end
            end
            ST_WR_REQ: begin
                // Second host access arriving while the write is still on the bus.
                if (ce_fall) begin
                    w_pend   = 1'b1;
                    w_shadow = mem_addr_i;
                end
                if (ce_rise && r_pend) begin
                    w_pend = 1'b0;
                end
                if (w_term) begin
                    w_wb_cyc = 1'b0;
                    w_wb_we  = 1'b0;
                    w_err    = w_bad;
                    if (w_pend) begin
                        w_wb_adr = w_shadow;
                        w_pend   = 1'b0;
                        w_state  = ST_ARMED;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_wb_cyc = 1'b0;
                w_state  = ST_IDLE;
            end
        endcase

        // Host stalls only while an access is decided or a read is outstanding.
        w_wait = (w_state == ST_ARMED) || (w_state == ST_RD_REQ);
    end

    assign mem_data_o  = r_mem_data;
    assign mem_data_oe = r_oe;
    assign mem_wait    = r_wait;
    assign wb_adr_o    = r_wb_adr;
    assign wb_dat_o    = r_wb_dat;
    assign wb_sel_o    = r_wb_sel;
    assign wb_we_o     = r_wb_we;
    assign wb_cyc_o    = r_wb_cyc;
    assign wb_stb_o    = r_wb_cyc;
    assign err_o       = r_err;

endmodule

// File: tb/tb_async_mem_wb_master.sv
// tb/tb_async_mem_wb_master.sv - directed scoreboard bench for async_mem_wb_master
module tb_async_mem_wb_master;

    localparam int TO_CYC = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_fall = 0, ce_rise = 0, we_rise = 0;
    logic        we_n_s = 1, oe_n_s = 1;
    logic [31:0] mem_addr_i = 0, mem_data_i = 0;
    logic [3:0]  mem_be_n_i = 0;
    logic [31:0] mem_data_o;
    logic        mem_data_oe, mem_wait;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = 0;
    logic        wb_ack_i = 0, wb_err_i = 0;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [31:0] rd_q[$];

    async_mem_wb_master #(.AW(32), .DW(32), .TO_CYC(TO_CYC), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .ce_fall(ce_fall), .ce_rise(ce_rise), .we_rise(we_rise),
        .we_n_s(we_n_s), .oe_n_s(oe_n_s),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_be_n_i(mem_be_n_i),
        .mem_data_o(mem_data_o), .mem_data_oe(mem_data_oe), .mem_wait(mem_wait),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ce_rise();
        ce_rise = 1'b1;
        tick();
        ce_rise = 1'b0;
    endtask

    task automatic start_read(input logic [31:0] a, input logic [31:0] rdata);
        wb_exp_t e;
        mem_addr_i = a;
        ce_fall    = 1'b1;
        tick();
        ce_fall    = 1'b0;
        oe_n_s     = 1'b0;
        check("armed_wait", {31'd0, mem_wait}, 32'd1);
        e.adr = a; e.we = 1'b0; e.dat = 32'd0; e.sel = ~mem_be_n_i;
        wb_q.push_back(e);
        rd_q.push_back(rdata);
    endtask

    // Waits (bounded) for a cycle and checks it against the next queued expectation.
    task automatic wb_accept();
        int      n;
        wb_exp_t e;
        n = 0;
        while (wb_cyc_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (wb_cyc_o !== 1'b1) begin
            check("cyc_start_timeout", {31'd0, wb_cyc_o}, 32'd1);
        end else if (wb_q.size() == 0) begin
            check("unexpected_cycle", 32'd1, 32'd0);
        end else begin
            e = wb_q.pop_front();
            check("wb_adr", wb_adr_o, e.adr);
            check("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
            check("wb_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
            check("wb_stb", {31'd0, wb_stb_o}, 32'd1);
            if (e.we) check("wb_dat", wb_dat_o, e.dat);
        end
    endtask

    task automatic wb_finish(input int lat, input logic [31:0] data, input logic err);
        repeat (lat) tick();
        wb_dat_i = data;
        wb_ack_i = !err;
        wb_err_i = err;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    endtask

    // At RD_HOLD entry: checks data/wait, OE assertion and OE release on ce_rise.
    task automatic finish_host_read();
        logic [31:0] exp_d;
        exp_d = rd_q.pop_front();
        check("rd_wait_low", {31'd0, mem_wait}, 32'd0);
        check("rd_data", mem_data_o, exp_d);
        tick();
        check("rd_oe_on", {31'd0, mem_data_oe}, 32'd1);
        repeat (3) tick();
        check("rd_oe_held", {31'd0, mem_data_oe}, 32'd1);
        pulse_ce_rise();
        check("rd_oe_off", {31'd0, mem_data_oe}, 32'd0);
        oe_n_s = 1'b1;
        tick();
    endtask

    initial begin
        wb_exp_t e;
        int      cnt;
        logic    seen_oe;

        repeat (3) tick();
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_wait", {31'd0, mem_wait}, 32'd0);
        check("rst_oe", {31'd0, mem_data_oe}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Read with ack after 3 cycles.
        mem_be_n_i = 4'b0000;
        start_read(32'h100, 32'hCAFE0001);
        wb_accept();
        wb_finish(3, 32'hCAFE0001, 1'b0);
        check("rd_no_err", {31'd0, err_o}, 32'd0);
        finish_host_read();

        // Posted write with partial byte enables.
        mem_addr_i = 32'h204;
        ce_fall    = 1'b1;
        tick();
        ce_fall = 1'b0;
        we_n_s  = 1'b0;
        check("wr_armed_wait", {31'd0, mem_wait}, 32'd1);
        tick();
        check("wr_wait_low", {31'd0, mem_wait}, 32'd0);
        mem_data_i = 32'h12345678;
        mem_be_n_i = 4'b1100;
        we_rise    = 1'b1;
        we_n_s     = 1'b1;
        e.adr = 32'h204; e.we = 1'b1; e.dat = 32'h12345678; e.sel = 4'b0011;
        wb_q.push_back(e);
        tick();
        we_rise = 1'b0;
        wb_accept();
        check("wr_posted_wait", {31'd0, mem_wait}, 32'd0);
        wb_finish(2, 32'h0, 1'b0);
        pulse_ce_rise();
        mem_be_n_i = 4'b0000;

        // Read timeout with a silent slave.
        start_read(32'h400, 32'hDEADBEEF);
        wb_accept();
        cnt = 0;
        while (wb_cyc_o === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        check("to_cyc_len", cnt, TO_CYC + 1);
        check("to_err_pulse", {31'd0, err_o}, 32'd1);
        finish_host_read();
        check("to_err_single", {31'd0, err_o}, 32'd0);

        // Overlap: posted write held 20 cycles while a read arrives.
        mem_addr_i = 32'h500;
        ce_fall    = 1'b1;
        tick();
        ce_fall = 1'b0;
        we_n_s  = 1'b0;
        tick();
        mem_data_i = 32'hAABBCCDD;
        we_rise    = 1'b1;
        we_n_s     = 1'b1;
        e.adr = 32'h500; e.we = 1'b1; e.dat = 32'hAABBCCDD; e.sel = 4'b1111;
        wb_q.push_back(e);
        tick();
        we_rise = 1'b0;
        wb_accept();
        pulse_ce_rise();
        mem_addr_i = 32'h300;
        ce_fall    = 1'b1;
        oe_n_s     = 1'b0;
        e.adr = 32'h300; e.we = 1'b0; e.dat = 32'h0; e.sel = 4'b1111;
        wb_q.push_back(e);
        rd_q.push_back(32'h5A5A0300);
        tick();
        ce_fall = 1'b0;
        repeat (17) tick();
        check("ovl_adr_hold", wb_adr_o, 32'h500);
        check("ovl_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
        wb_finish(0, 32'h0, 1'b0);
        check("ovl_shadow_adr", wb_adr_o, 32'h300);
        check("ovl_armed_wait", {31'd0, mem_wait}, 32'd1);
        wb_accept();
        wb_finish(1, 32'h5A5A0300, 1'b0);
        finish_host_read();

        // Abort before OE/WE: no cycle at all.
        mem_addr_i = 32'h600;
        ce_fall    = 1'b1;
        tick();
        ce_fall = 1'b0;
        tick();
        pulse_ce_rise();
        cnt = 0;
        repeat (10) begin
            if (wb_cyc_o !== 1'b0) cnt++;
            tick();
        end
        check("abort1_no_cyc", cnt, 0);
        check("abort1_wait", {31'd0, mem_wait}, 32'd0);

        // Abort during RD_REQ: cycle completes, OE never set.
        start_read(32'h700, 32'h0);
        void'(rd_q.pop_back());
        wb_accept();
        pulse_ce_rise();
        wb_finish(2, 32'h11111111, 1'b0);
        seen_oe = 1'b0;
        repeat (5) begin
            tick();
            if (mem_data_oe !== 1'b0) seen_oe = 1'b1;
        end
        check("abort2_no_oe", {31'd0, seen_oe}, 32'd0);
        check("abort2_wait", {31'd0, mem_wait}, 32'd0);
        check("abort2_data_kept", mem_data_o, 32'h5A5A0300);
        oe_n_s = 1'b1;
        tick();

        // Reset during RD_REQ, then a normal read.
        start_read(32'h800, 32'h0);
        void'(rd_q.pop_back());
        wb_accept();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_mid_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_mid_oe", {31'd0, mem_data_oe}, 32'd0);
        check("rst_mid_wait", {31'd0, mem_wait}, 32'd0);
        tick();
        rst    = 1'b0;
        oe_n_s = 1'b1;
        tick();
        start_read(32'h900, 32'h0BADF00D);
        wb_accept();
        wb_finish(1, 32'h0BADF00D, 1'b0);
        finish_host_read();

        check("queue_empty", wb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
